vga_timing_core: RTL and testbench
==================================

# vga_timing_core

Parametrised VGA timing and pixel-output core: the next-generation replacement for the fixed 640x480 `vgaDriver`. It adds configurable resolution and porches, sync polarity, per-channel colour widths, an internal pixel-clock divider, and a compensated pixel-source latency. It sits between the pixel source (pattern generator / image processor / mux) and the VGA pins. It issues row/column requests and aligns returned RGB data with the delayed sync and blanking.

## Interface
Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active low)
- R_W / G_W / B_W, 5 / 6 / 5, colour channel widths
- CLK_DIV, 2, clk cycles per pixel (>=1)
- PIX_LAT, 0, pixel-source latency in pixel ticks (0..7)

Derived values:
- H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP
- V_TOTAL = V_ACT+V_FP+V_SYNC+V_BP
- H_W = $clog2(H_TOTAL)
- V_W = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- rgb_i  in  R_W+G_W+B_W  pixel data {R,G,B} for the coordinate issued PIX_LAT ticks earlier
- column_o  out  H_W  current horizontal counter
- row_o  out  V_W  current vertical counter
- active_o  out  1  (column_o<H_ACT)&&(row_o<V_ACT), undelayed request-valid
- frame_start_o  out  1  one-clk pulse at start of each frame
- red_o / green_o / blue_o  out  R_W / G_W / B_W  registered colour outputs
- hsync_o / vsync_o  out  1  registered sync outputs
- de_o  out  1  registered display enable, aligned with colour outputs

## Operation
Pixel tick:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- tick = (div_cnt==CLK_DIV-1).
- With CLK_DIV=1, tick is high every cycle.

Counters:
- Both counters advance only on tick.
- h_cnt runs 0..H_TOTAL-1. On wrap, v_cnt increments, wrapping at V_TOTAL-1.
- column_o = h_cnt; row_o = v_cnt.

Stage-0 decode, combinational from the counters:
- act = active_o.
- hs = h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1].
- vs = v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1].

Delay line:
- {act,hs,vs} passes through a PIX_LAT-deep shift register, advanced on tick. With PIX_LAT=0 there is no delay line.

Output register, loaded on tick:
- de_o <= delayed act.
- hsync_o <= delayed hs ? SYNC_POL : ~SYNC_POL; vsync_o likewise.
- Colours <= delayed act ? rgb_i fields : 0.
- Blanking therefore forces every colour bit to 0 regardless of rgb_i.

frame_start_o:
- High for exactly the one clk cycle where tick && h_cnt==0 && v_cnt==0.
- This includes the first frame after reset.

Reset (rst_n low at a clk edge):
- Next cycle: div_cnt, h_cnt, v_cnt = 0; delay line cleared to {0, inactive, inactive}.
- de_o=0, hsync_o=vsync_o=~SYNC_POL, colours=0, frame_start_o=0.
- Reset mid-frame aborts the frame immediately. No partial-line recovery is required.

## Timing
- First tick: clk cycle CLK_DIV-1 after rst_n is sampled high.
- Output latency: registered outputs reflect the counter state PIX_LAT+1 ticks earlier.
- rgb_i sampling: rgb_i must be valid during the tick cycle PIX_LAT ticks after its coordinate was presented. It is sampled only in tick cycles.
- Line period: H_TOTAL*CLK_DIV clk. Frame period: H_TOTAL*V_TOTAL*CLK_DIV clk (defaults: 1600 and 840000).
- Sync pulse widths: H_SYNC ticks (hsync) and V_SYNC lines (vsync).
- Output update: outputs change only on the clk edge ending a tick cycle, and are stable between ticks.

## Test plan
- **Reset:** hold rst_n=0 for 5 cycles, defaults -> hsync_o=vsync_o=1, de_o=0, colours=0, row_o=column_o=0; frame_start_o pulses at clk cycle 1 after release.
- **Default timing:** run 2 frames -> hsync low 192 clk every 1600 clk; vsync low 3200 clk every 840000 clk; de_o high 1280 clk per line for exactly 480 lines per frame.
- **Latency alignment:** PIX_LAT=2, model source returns rgb_i={column[4:0],row[5:0],column[4:0]} two ticks late -> first de_o pixel of line 7 is {0,7,0}; the 640th is {31,7,31}; hsync asserts 656 ticks after the de_o rising edge.
- **Blank masking:** rgb_i tied all-ones -> colours=16'hFFFF only while de_o=1; 0 in every blanking cycle, including porches and sync.
- **Mid-frame reset:** pulse rst_n=0 for one cycle at h=300, v=200 -> next cycle counters=0, outputs inactive; a full normal frame follows, with frame_start_o at first tick.
- **Small/positive config:** H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, SYNC_POL=1, PIX_LAT=0 -> line period 8 clk; hsync high at h_cnt 5..6 (outputs one clk later); vsync high 8 clk per 48-clk frame.

Source files
------------

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA sync/blanking generator with latency-compensated registered pixel output
module vga_timing_core #(
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 0,
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP,
  localparam int H_W     = $clog2(H_TOTAL),
  localparam int V_W     = $clog2(V_TOTAL),
  localparam int RGB_W   = R_W + G_W + B_W,
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] rgb_i,
  output logic [H_W-1:0]   column_o,
  output logic [V_W-1:0]   row_o,
  output logic             active_o,
  output logic             frame_start_o,
  output logic [R_W-1:0]   red_o,
  output logic [G_W-1:0]   green_o,
  output logic [B_W-1:0]   blue_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
);
  localparam logic SP = SYNC_POL[0];
  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic tick, h_last, act, hs, vs, d_act, d_hs, d_vs;
  assign tick = div_cnt == DIV_W'(CLK_DIV - 1);
  assign h_last = h_cnt == H_W'(H_TOTAL - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_cnt == V_W'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
      end
    end
  assign act = (h_cnt < H_W'(H_ACT)) && (v_cnt < V_W'(V_ACT));
  assign hs = (h_cnt >= H_W'(H_ACT + H_FP)) && (h_cnt <= H_W'(H_ACT + H_FP + H_SYNC - 1));
  assign vs = (v_cnt >= V_W'(V_ACT + V_FP)) && (v_cnt <= V_W'(V_ACT + V_FP + V_SYNC - 1));
  // Delay the decode so it lines up with rgb_i returned by a source PIX_LAT ticks behind
  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign {d_act, d_hs, d_vs} = {act, hs, vs};
    end else begin : g_dly
      logic [2:0] dly [PIX_LAT];
      always_ff @(posedge clk)
        if (!rst_n) dly <= '{default: '0};
        else if (tick) begin
          dly[0] <= {act, hs, vs};
          for (int i = 1; i < PIX_LAT; i++) dly[i] <= dly[i-1];
        end
      assign {d_act, d_hs, d_vs} = dly[PIX_LAT-1];
    end
  endgenerate
  always_ff @(posedge clk)
    if (!rst_n) begin
      de_o <= 1'b0;
      hsync_o <= ~SP;
      vsync_o <= ~SP;
      red_o <= '0;
      green_o <= '0;
      blue_o <= '0;
    end else if (tick) begin
      de_o <= d_act;
      hsync_o <= d_hs ? SP : ~SP;
      vsync_o <= d_vs ? SP : ~SP;
      red_o <= d_act ? rgb_i[RGB_W-1 -: R_W] : '0;
      green_o <= d_act ? rgb_i[G_W+B_W-1 -: G_W] : '0;
      blue_o <= d_act ? rgb_i[B_W-1:0] : '0;
    end
  assign column_o = h_cnt;
  assign row_o = v_cnt;
  assign active_o = act;
  // Gated by rst_n so a held reset never shows a frame start, even when every cycle is a tick
  assign frame_start_o = rst_n && tick && h_cnt == '0 && v_cnt == '0;
endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed checks of reset, line timing, latency alignment, blank masking, mid-frame reset and a small positive-sync config
module tb_vga_timing_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic rst0 = 1'b0;
  logic [15:0] rgb0 = 16'hFFFF;
  logic [9:0] col0, row0;
  logic act0, fs0, hs0, vs0, de0;
  logic [4:0] r0, b0;
  logic [5:0] g0;
  vga_timing_core u0 (
    .clk(clk), .rst_n(rst0), .rgb_i(rgb0), .column_o(col0), .row_o(row0),
    .active_o(act0), .frame_start_o(fs0), .red_o(r0), .green_o(g0), .blue_o(b0),
    .hsync_o(hs0), .vsync_o(vs0), .de_o(de0)
  );
  logic rst1 = 1'b0;
  logic [15:0] rgb1, p0, p1;
  logic [9:0] col1, row1;
  logic act1, fs1, hs1, vs1, de1;
  logic [4:0] r1, b1;
  logic [5:0] g1;
  vga_timing_core #(.CLK_DIV(1), .PIX_LAT(2)) u1 (
    .clk(clk), .rst_n(rst1), .rgb_i(rgb1), .column_o(col1), .row_o(row1),
    .active_o(act1), .frame_start_o(fs1), .red_o(r1), .green_o(g1), .blue_o(b1),
    .hsync_o(hs1), .vsync_o(vs1), .de_o(de1)
  );
  // Pixel source with a two-tick latency (one tick per clk here)
  always @(posedge clk) begin
    p0 <= {col1[4:0], row1[5:0], col1[4:0]};
    p1 <= p0;
  end
  assign rgb1 = p1;
  logic rst2 = 1'b0;
  logic [15:0] rgb2 = 16'hFFFF;
  logic [2:0] col2, row2;
  logic act2, fs2, hs2, vs2, de2;
  logic [4:0] r2, b2;
  logic [5:0] g2;
  vga_timing_core #(
    .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .CLK_DIV(1), .PIX_LAT(0)
  ) u2 (
    .clk(clk), .rst_n(rst2), .rgb_i(rgb2), .column_o(col2), .row_o(row2),
    .active_o(act2), .frame_start_o(fs2), .red_o(r2), .green_o(g2), .blue_o(b2),
    .hsync_o(hs2), .vsync_o(vs2), .de_o(de2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  int mh, mv, vs_hi;
  logic e_de, e_hs, e_vs;
  // Small-config model: mh/mv is the counter this cycle, e_* the outputs loaded from the previous tick
  task automatic run_small(input int n);
    for (int k = 0; k < n; k++) begin
      chk("s_col", col2, mh);
      chk("s_row", row2, mv);
      chk("s_act", act2, mh < 4 && mv < 3);
      chk("s_fs", fs2, mh == 0 && mv == 0);
      chk("s_de", de2, e_de);
      chk("s_hs", hs2, e_hs);
      chk("s_vs", vs2, e_vs);
      chk("s_rgb", {r2, g2, b2}, e_de ? 16'hFFFF : 16'h0);
      vs_hi += vs2;
      e_de = mh < 4 && mv < 3;
      e_hs = mh >= 5 && mh <= 6;
      e_vs = mv == 4;
      mh = (mh + 1) % 8;
      if (mh == 0) mv = (mv + 1) % 6;
      step;
    end
  endtask
  initial begin
    int n, rises, de_cnt, hs_lo, vs_lo, fs_cnt, f1, f2;
    logic prev;
    repeat (5) step;
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_de", de0, 0);
    chk("rst_rgb", {r0, g0, b0}, 0);
    chk("rst_col", col0, 0);
    chk("rst_row", row0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_act", act0, 1);
    rst0 = 1'b1;
    step;
    chk("fs_first", fs0, 1);
    chk("fs_col", col0, 0);
    de_cnt = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0; f1 = -1; f2 = -1; prev = 1'b1;
    for (int i = 0; i < 3200; i++) begin
      chk("blank_mask", {r0, g0, b0}, de0 ? 16'hFFFF : 16'h0);
      de_cnt += int'(de0);
      hs_lo += int'(!hs0);
      vs_lo += int'(!vs0);
      fs_cnt += int'(fs0);
      if (prev && !hs0) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      prev = hs0;
      step;
    end
    chk("de_clks_2lines", de_cnt, 2560);
    chk("hs_low_clks_2lines", hs_lo, 384);
    chk("hs_first_fall", f1, 1313);
    chk("hs_second_fall", f2, 2913);
    chk("vs_low_clks", vs_lo, 0);
    chk("fs_count", fs_cnt, 1);
    n = 0;
    while (col0 != 10'd300 && n < 4000) begin
      step;
      n++;
    end
    chk("wait_col300", col0, 300);
    rst0 = 1'b0;
    step;
    chk("mrst_col", col0, 0);
    chk("mrst_row", row0, 0);
    chk("mrst_de", de0, 0);
    chk("mrst_hs", hs0, 1);
    chk("mrst_vs", vs0, 1);
    chk("mrst_rgb", {r0, g0, b0}, 0);
    chk("mrst_fs", fs0, 0);
    rst0 = 1'b1;
    step;
    chk("mrst_fs_after", fs0, 1);
    rst1 = 1'b1;
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 8 && n < 8000) begin
      step;
      n++;
      if (de1 && !prev) rises++;
      prev = de1;
    end
    chk("lat_rise_found", rises, 8);
    chk("lat_first", {r1, g1, b1}, {5'd0, 6'd7, 5'd0});
    chk("lat_first_de", de1, 1);
    chk("lat_first_act", act1, 1);
    repeat (639) step;
    chk("lat_640th", {r1, g1, b1}, {5'd31, 6'd7, 5'd31});
    chk("lat_640th_de", de1, 1);
    step;
    chk("lat_end_de", de1, 0);
    chk("lat_end_rgb", {r1, g1, b1}, 0);
    repeat (15) step;
    chk("lat_hs_655", hs1, 1);
    step;
    chk("lat_hs_656", hs1, 0);
    mh = 0; mv = 0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; vs_hi = 0;
    rst2 = 1'b1;
    #1;
    run_small(96);
    chk("s_vs_high_2frames", vs_hi, 16);
    run_small(19);
    rst2 = 1'b0;
    step;
    chk("s_mrst_col", col2, 0);
    chk("s_mrst_row", row2, 0);
    chk("s_mrst_de", de2, 0);
    chk("s_mrst_hs", hs2, 0);
    chk("s_mrst_vs", vs2, 0);
    chk("s_mrst_rgb", {r2, g2, b2}, 0);
    chk("s_mrst_fs", fs2, 0);
    mh = 0; mv = 0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; vs_hi = 0;
    rst2 = 1'b1;
    #1;
    run_small(48);
    chk("s_vs_high_frame", vs_hi, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
